// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin burst arbiter feeding one shared, registered downstream stream
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req_data     requester i beat at [i*D_WIDTH +: D_WIDTH]
//   req_valid    per-requester valid
//   req_ready    per-requester ready, only the granted bit can be high
//   down_data    registered beat to the processing chain
//   down_id      source index of down_data
//   down_valid   registered valid to the chain
//   down_ready   chain ready
//   grant_active high while a requester holds the grant
module rr_stream_arbiter #(
  parameter int D_WIDTH   = 6,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*D_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  output logic [D_WIDTH-1:0]       down_data,
  output logic [ID_W-1:0]          down_id,
  output logic                     down_valid,
  input  logic                     down_ready,
  output logic                     grant_active
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, grant, grant_n, grant_inc, pick, idx;
  logic [CW-1:0] beat_cnt, beat_n;
  logic [D_WIDTH-1:0] sel_data;
  logic pipe_ready, xfer, last;
  // first valid requester at or after ptr; walking downward lets the nearest one win
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant == ID_W'(i)) sel_data = req_data[i*D_WIDTH +: D_WIDTH];
  end
  assign pipe_ready   = !down_valid || down_ready;
  assign xfer         = state == GRANT && req_valid[grant] && pipe_ready;
  assign last         = beat_cnt == CW'(MAX_BURST - 1);
  assign grant_inc    = grant == ID_W'(N_REQ - 1) ? '0 : grant + 1'b1;
  assign req_ready    = xfer ? N_REQ'(1) << grant : '0;
  assign grant_active = state == GRANT;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    beat_n  = beat_cnt;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_n = GRANT;
        grant_n = pick;
        beat_n  = '0;
      end
    end else if (xfer) begin
      beat_n  = last ? '0 : beat_cnt + 1'b1;
      state_n = last ? IDLE : GRANT;
      ptr_n   = last ? grant_inc : ptr;
    end else if (!req_valid[grant]) begin
      state_n = IDLE;
      ptr_n   = grant_inc;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      beat_cnt   <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_id    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      beat_cnt <= beat_n;
      if (xfer) begin
        down_valid <= 1'b1;
        down_data  <= sel_data;
        down_id    <= grant;
      end else if (down_ready) begin
        down_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: scoreboard bench against a queue-based arbitration model
module tb_rr_stream_arbiter;
  localparam int DW = 6;
  localparam int N  = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [DW-1:0] down_data;
  logic [1:0] down_id;
  logic down_valid;
  logic down_ready = 1'b0;
  logic grant_active;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] src [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] e;
  bit on = 0;
  bit m_gr, m_dv;
  int m_g, m_ptr, m_cnt, m_did;
  logic [DW-1:0] m_dd;
  always #5 clk = ~clk;
  rr_stream_arbiter #(.D_WIDTH(DW), .N_REQ(N), .MAX_BURST(MB), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .down_data(down_data), .down_id(down_id), .down_valid(down_valid), .down_ready(down_ready),
    .grant_active(grant_active)
  );
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] exp_ready();
    return (m_gr && req_valid[m_g] && (!m_dv || down_ready)) ? N'(1) << m_g : '0;
  endfunction
  task automatic model_reset();
    m_gr = 0; m_dv = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_did = 0; m_dd = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src[i].delete();
  endtask
  task automatic clear();
    for (int i = 0; i < N; i++) src[i].delete();
  endtask
  task automatic load(int i, int n);
    repeat (n) src[i].push_back(DW'($urandom));
  endtask
  task automatic drive(int vp, int rp);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = src[i].size() > 0 && $urandom_range(99) < vp;
      if (src[i].size() > 0) req_data[i*DW +: DW] = src[i][0];
      else req_data[i*DW +: DW] = DW'($urandom);
    end
    down_ready = $urandom_range(99) < rp;
  endtask
  // one clock: apply the arbitration rules to the inputs seen at this edge, then drive new ones
  task automatic step(int vp, int rp);
    bit x;
    @(posedge clk);
    x = m_gr && req_valid[m_g] && (!m_dv || down_ready);
    if (!m_gr) begin
      for (int k = 0; k < N && !m_gr; k++)
        if (req_valid[(m_ptr + k) % N]) begin
          m_gr = 1; m_g = (m_ptr + k) % N; m_cnt = 0;
        end
    end else if (x) begin
      m_dd = req_data[m_g*DW +: DW];
      m_did = m_g;
      exp_q.push_back({2'(m_g), m_dd});
      void'(src[m_g].pop_front());
      m_cnt++;
      if (m_cnt == MB) begin m_gr = 0; m_ptr = (m_g + 1) % N; end
    end else if (!req_valid[m_g]) begin
      m_gr = 0; m_ptr = (m_g + 1) % N;
    end
    m_dv = x ? 1'b1 : (down_ready ? 1'b0 : m_dv);
    #1 drive(vp, rp);
  endtask
  task automatic drain();
    repeat (8) step(0, 100);
    clear();
  endtask
  always @(negedge clk) if (on) begin
    check("req_ready", req_ready, exp_ready());
    check("grant_active", grant_active, m_gr);
    check("down_valid", down_valid, m_dv);
    if (m_dv) begin
      check("down_data", down_data, m_dd);
      check("down_id", down_id, m_did);
    end
    if (down_valid && down_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_beat actual=unexpected beat %0h required=none at %0t", {down_id, down_data}, $time);
      end else begin
        e = exp_q.pop_front();
        checks--;
        check("sb_beat", {down_id, down_data}, e);
      end
    end
  end
  initial begin
    model_reset();
    req_valid = '1;
    down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t1_rst_down_valid", down_valid, 0);
    check("t1_rst_req_ready", req_ready, 0);
    check("t1_rst_grant_active", grant_active, 0);
    check("t1_rst_down_data", down_data, 0);
    check("t1_rst_down_id", down_id, 0);
    for (int i = 0; i < N; i++) load(i, 12);
    drive(100, 100);
    rst = 1'b1;
    on = 1;
    step(100, 100);
    #2 check("t1_first_grant", req_ready, 4'b0001);
    repeat (70) step(100, 100);
    drain();
    load(2, 6);
    repeat (14) step(100, 100);
    drain();
    load(1, 6);
    repeat (3) step(100, 100);
    repeat (5) step(100, 0);
    repeat (10) step(100, 100);
    drain();
    load(3, 2);
    repeat (2) step(100, 100);
    load(0, 4);
    repeat (14) step(100, 100);
    drain();
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (src[i].size() < 2 && $urandom_range(3) == 0) load(i, $urandom_range(1, 6));
      step(70, 60);
    end
    drain();
    for (int i = 0; i < N; i++) load(i, 8);
    repeat (4) step(100, 100);
    #2 check("t6_pre_down_valid", down_valid, 1);
    on = 0;
    rst = 1'b0;
    #1;
    check("t6_rst_down_valid", down_valid, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_grant_active", grant_active, 0);
    check("t6_rst_down_data", down_data, 0);
    check("t6_rst_down_id", down_id, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) load(i, 4);
    drive(100, 100);
    rst = 1'b1;
    on = 1;
    step(100, 100);
    #2 check("t6_first_grant", req_ready, 4'b0001);
    repeat (30) step(100, 100);
    drain();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
